// File: rtl/pio_tx_fifo.sv
// PIO transmit FIFO: first-word-fall-through circular buffer whose depth
// doubles when join is set, with sticky overflow/stall flags and a DMA request.
module pio_tx_fifo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned BASE_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pull_i,
  output logic [WIDTH-1:0] pull_data_o,
  output logic             pull_valid_o,
  input  logic             join_i,
  input  logic             flush_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [$clog2(2*BASE_DEPTH):0] level_o,
  output logic             dreq_o,
  output logic             txover_o,
  output logic             txstall_o,
  input  logic             clr_over_i,
  input  logic             clr_stall_i
);

  localparam int unsigned DEPTH = 2 * BASE_DEPTH;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_inc_c, rptr_inc_c;
  logic [LVL_W-1:0] level_q, level_d;
  logic [LVL_W-1:0] cap_c, last_c;
  logic             txover_q, txover_d, txstall_q, txstall_d;
  logic             join_q;
  logic             do_push, do_pull, set_over, set_stall, clear_c;

  // Capacity follows the registered join so flags never glitch on the input.
  assign cap_c  = join_q ? LVL_W'(DEPTH) : LVL_W'(BASE_DEPTH);
  assign last_c = cap_c - LVL_W'(1);

  assign wptr_inc_c = (LVL_W'(wptr_q) == last_c) ? '0 : wptr_q + PTR_W'(1);
  assign rptr_inc_c = (LVL_W'(rptr_q) == last_c) ? '0 : rptr_q + PTR_W'(1);

  assign full_o       = (level_q == cap_c);
  assign empty_o      = (level_q == '0);
  assign pull_valid_o = ~empty_o;
  assign dreq_o       = ~full_o;
  assign level_o      = level_q;
  assign txover_o     = txover_q;
  assign txstall_o    = txstall_q;
  assign pull_data_o  = mem_q[rptr_q];

  // A join change repartitions storage, so it discards contents like flush.
  assign clear_c = flush_i | (join_i != join_q);

  // Next-state for pointers, occupancy and sticky flags.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    level_d   = level_q;
    do_push   = 1'b0;
    do_pull   = 1'b0;
    set_over  = 1'b0;
    set_stall = 1'b0;
    if (clear_c) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      // When full, a same-cycle pull frees the slot the push lands in.
      do_pull   = pull_i & ~empty_o;
      do_push   = push_i & (~full_o | pull_i);
      set_over  = push_i & full_o & ~pull_i;
      set_stall = pull_i & empty_o;
      if (do_push) wptr_d = wptr_inc_c;
      if (do_pull) rptr_d = rptr_inc_c;
      level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pull);
    end
    txover_d  = set_over  | (txover_q  & ~clr_over_i);
    txstall_d = set_stall | (txstall_q & ~clr_stall_i);
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      txover_q  <= 1'b0;
      txstall_q <= 1'b0;
      join_q    <= join_i;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      txover_q  <= txover_d;
      txstall_q <= txstall_d;
      join_q    <= join_i;
    end
  end

  // Storage write; contents are not reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i && do_push) begin
      mem_q[wptr_q] <= push_data_i;
    end
  end

endmodule
